// File: rtl/ex_mem_if.sv
// EX/MEM stage bundle: EX-side inputs, MEM-side registered outputs, redirect and perf counters.
// The slave modport is the pipeline register; the master modport is whatever drives EX and consumes MEM.
interface ex_mem_if #(
  parameter int REG_NUM_BITWIDTH = 5,
  parameter int WORD_BITWIDTH    = 32
);
  localparam int BE_W = WORD_BITWIDTH / 8;

  logic                        stall;
  logic                        flush;
  logic                        ex_valid;
  logic                        memToReg;
  logic                        regWrite;
  logic                        memRead;
  logic                        memWrite;
  logic                        branch;
  logic                        jump;
  logic                        jalr;
  logic [2:0]                  funct3;
  logic [WORD_BITWIDTH-1:0]    ALUresult;
  logic [WORD_BITWIDTH-1:0]    readData1;
  logic [WORD_BITWIDTH-1:0]    readData2;
  logic [REG_NUM_BITWIDTH-1:0] regToWrite;
  logic [WORD_BITWIDTH-1:0]    ex_pc;
  logic [WORD_BITWIDTH-1:0]    ex_imm;

  logic                        pc_src;
  logic [WORD_BITWIDTH-1:0]    branch_pc;
  logic                        mem_valid;
  logic                        mem_memToReg;
  logic                        mem_regWrite;
  logic                        mem_memRead;
  logic                        mem_memWrite;
  logic [WORD_BITWIDTH-1:0]    mem_result;
  logic [WORD_BITWIDTH-1:0]    mem_storeData;
  logic [BE_W-1:0]             mem_byteEn;
  logic [2:0]                  mem_funct3;
  logic [REG_NUM_BITWIDTH-1:0] mem_regToWrite;
  logic                        mem_misaligned;
  logic [31:0]                 perf_branches;
  logic [31:0]                 perf_taken;

  modport slave (
    input  stall, flush, ex_valid, memToReg, regWrite, memRead, memWrite,
           branch, jump, jalr, funct3, ALUresult, readData1, readData2,
           regToWrite, ex_pc, ex_imm,
    output pc_src, branch_pc, mem_valid, mem_memToReg, mem_regWrite,
           mem_memRead, mem_memWrite, mem_result, mem_storeData, mem_byteEn,
           mem_funct3, mem_regToWrite, mem_misaligned, perf_branches, perf_taken
  );

  modport master (
    output stall, flush, ex_valid, memToReg, regWrite, memRead, memWrite,
           branch, jump, jalr, funct3, ALUresult, readData1, readData2,
           regToWrite, ex_pc, ex_imm,
    input  pc_src, branch_pc, mem_valid, mem_memToReg, mem_regWrite,
           mem_memRead, mem_memWrite, mem_result, mem_storeData, mem_byteEn,
           mem_funct3, mem_regToWrite, mem_misaligned, perf_branches, perf_taken
  );
endinterface

// File: rtl/ex_mem_stage_reg.sv
// EX/MEM pipeline register with branch resolution, link select, byte-lane generation and misalignment squash.
// Optional branch perf counters are built only when EX_MEM_PERF_EN is defined.
module ex_mem_stage_reg #(
  parameter int REG_NUM_BITWIDTH = 5,
  parameter int WORD_BITWIDTH    = 32
) (
  input  logic     clk,
  input  logic     rst,
  ex_mem_if.slave  bus
);
  localparam int BE_W  = WORD_BITWIDTH / 8;
  localparam int OFS_W = $clog2(BE_W);

  logic                        advance;
  logic                        eq, lt_s, lt_u, cond;
  logic                        mem_op, mis_raw, mis;
  logic [1:0]                  size;
  logic [OFS_W-1:0]            ofs;
  logic [BE_W-1:0]             size_mask;
  logic [BE_W-1:0]             be_next;
  logic [WORD_BITWIDTH-1:0]    sd_next;
  logic [WORD_BITWIDTH-1:0]    res_next;
  logic [REG_NUM_BITWIDTH-1:0] rd_next;

  assign advance = ~bus.stall & ~bus.flush;

  assign eq   = bus.readData1 == bus.readData2;
  assign lt_s = $signed(bus.readData1) < $signed(bus.readData2);
  assign lt_u = bus.readData1 < bus.readData2;

  always_comb begin
    cond = 1'b0;
    case (bus.funct3)
      3'b000:  cond = eq;
      3'b001:  cond = ~eq;
      3'b100:  cond = lt_s;
      3'b101:  cond = ~lt_s;
      3'b110:  cond = lt_u;
      3'b111:  cond = ~lt_u;
      default: cond = 1'b0;
    endcase
  end

  assign bus.pc_src    = bus.ex_valid & advance & ((bus.branch & cond) | bus.jump);
  assign bus.branch_pc = bus.jalr ? ((bus.readData1 + bus.ex_imm) & ~{{(WORD_BITWIDTH-1){1'b0}}, 1'b1})
                                  : (bus.ex_pc + bus.ex_imm);

  assign size   = bus.funct3[1:0];
  assign ofs    = bus.ALUresult[OFS_W-1:0];
  assign mem_op = bus.memRead | bus.memWrite;

  always_comb begin
    size_mask = '0;
    mis_raw   = 1'b0;
    sd_next   = bus.readData2;
    case (size)
      2'b00: begin
        size_mask = BE_W'(1);
        sd_next   = {BE_W{bus.readData2[7:0]}};
      end
      2'b01: begin
        size_mask = BE_W'(3);
        mis_raw   = ofs[0];
        sd_next   = {(BE_W/2){bus.readData2[15:0]}};
      end
      2'b10: begin
        size_mask = BE_W'(15);
        mis_raw   = ofs[1:0] != 2'b00;
        sd_next   = {(BE_W/4){bus.readData2[31:0]}};
      end
      default: begin
        // double: only a 64-bit build can issue it, and only on an 8-byte boundary
        size_mask = '1;
        mis_raw   = (WORD_BITWIDTH == 32) || (ofs != '0);
        sd_next   = bus.readData2;
      end
    endcase
  end

  assign mis      = mem_op & mis_raw;
  assign be_next  = (mem_op & ~mis) ? (size_mask << ofs) : '0;
  assign res_next = bus.jump ? (bus.ex_pc + WORD_BITWIDTH'(4)) : bus.ALUresult;
  assign rd_next  = bus.regToWrite;

  always_ff @(posedge clk or posedge rst) begin
    if (rst || bus.flush) begin
      bus.mem_valid      <= 1'b0;
      bus.mem_memToReg   <= 1'b0;
      bus.mem_regWrite   <= 1'b0;
      bus.mem_memRead    <= 1'b0;
      bus.mem_memWrite   <= 1'b0;
      bus.mem_result     <= '0;
      bus.mem_storeData  <= '0;
      bus.mem_byteEn     <= '0;
      bus.mem_funct3     <= '0;
      bus.mem_regToWrite <= '0;
      bus.mem_misaligned <= 1'b0;
    end else if (!bus.stall) begin
      bus.mem_valid      <= bus.ex_valid;
      bus.mem_memToReg   <= bus.ex_valid & bus.memToReg;
      bus.mem_regWrite   <= bus.ex_valid & bus.regWrite & ~mis;
      bus.mem_memRead    <= bus.ex_valid & bus.memRead & ~mis;
      bus.mem_memWrite   <= bus.ex_valid & bus.memWrite & ~mis;
      bus.mem_result     <= res_next;
      bus.mem_storeData  <= sd_next;
      bus.mem_byteEn     <= be_next;
      bus.mem_funct3     <= bus.funct3;
      bus.mem_regToWrite <= rd_next;
      bus.mem_misaligned <= bus.ex_valid & mis;
    end
  end

`ifdef EX_MEM_PERF_EN
  logic [31:0] perf_br_q, perf_tk_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_br_q <= '0;
      perf_tk_q <= '0;
    end else if (bus.ex_valid && bus.branch && advance) begin
      if (perf_br_q != '1)
        perf_br_q <= perf_br_q + 32'd1;
      if (cond && perf_tk_q != '1)
        perf_tk_q <= perf_tk_q + 32'd1;
    end
  end

  assign bus.perf_branches = perf_br_q;
  assign bus.perf_taken    = perf_tk_q;
`else
  assign bus.perf_branches = '0;
  assign bus.perf_taken    = '0;
`endif
endmodule
